add_pipe: RTL and testbench

Parametrised, pipelined two-operand adder/subtractor with cin/cout and signed-overflow flag. It extends the 1-bit full adder to WIDTH bits, split into STAGES chunk stages. It uses a valid/ready handshake on both sides, so it can sit directly in the DSP datapath between streaming producers and consumers. Throughput is one operation per cycle, and backpressure stalls the whole pipeline.

---
 rtl/add_pipe_pkg.sv | 19 +
 rtl/add_chunk.sv | 27 ++
 rtl/add_pipe.sv | 137 +++++++++++++
 tb/tb_add_pipe.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
package add_pipe_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Bit offset of stage k's b-operand segment in the triangular skew bus:
    // stage k still needs (width - k*chunk) bits of b.
    function automatic int b_off(input int k, input int width, input int chunk);
        return k * width - chunk * ((k * (k - 1)) / 2);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder slice: sum, carry out, and the carry into its MSB.
module add_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    if (W == 1) begin : g_bit
        assign o_cmsb = i_cin;
        assign o_sum  = i_a ^ i_b ^ i_cin;
    end else begin : g_vec
        logic [W-1:0] w_low;

        // W-1 low bits plus carry-in; the extra top bit is the carry into the MSB
        assign w_low  = {1'b0, i_a[W-2:0]} + {1'b0, i_b[W-2:0]} + {{(W-1){1'b0}}, i_cin};
        assign o_cmsb = w_low[W-1];
        assign o_sum  = {i_a[W-1] ^ i_b[W-1] ^ w_low[W-1], w_low[W-2:0]};
    end

    assign o_cout = (i_a[W-1] & i_b[W-1]) | (o_cmsb & (i_a[W-1] ^ i_b[W-1]));

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit carry slice per stage,
// with a global stall enable driven by output backpressure.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int BTOT  = b_off(STAGES, WIDTH, CHUNK);

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("add_pipe: WIDTH must be a multiple of STAGES");
    end

    logic             w_en;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_prep;
    logic             w_c0;

    // w_x[k] packs {finished sum chunks (top), unconsumed a chunks (bottom)}
    // entering stage k; the two always total WIDTH bits.
    logic [WIDTH-1:0] w_x [STAGES+1];
    logic             w_c [STAGES+1];
    logic             w_v [STAGES+1];
    logic [BTOT-1:0]  w_b_flat;
    logic             r_cmsb;

    assign w_is_sub = (op_e'(op) == OP_SUB);
    assign w_b_prep = w_is_sub ? ~b : b;
    assign w_c0     = w_is_sub ? 1'b1 : cin;

    assign w_en     = ~out_valid | out_ready;
    assign in_ready = w_en;

    assign w_x[0]             = a;
    assign w_c[0]             = w_c0;
    assign w_v[0]             = in_valid;
    assign w_b_flat[0+:WIDTH] = w_b_prep;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * CHUNK;
        localparam int BO  = b_off(k, WIDTH, CHUNK);

        logic [REM-1:0]   w_b_in;
        logic [CHUNK-1:0] w_csum;
        logic             w_cout;
        logic             w_cmsb;
        logic [WIDTH-1:0] w_x_next;
        logic [WIDTH-1:0] r_x;
        logic             r_c;
        logic             r_v;

        assign w_b_in = w_b_flat[BO+:REM];

        add_chunk #(
            .W(CHUNK)
        ) u_add (
            .i_a   (w_x[k][CHUNK-1:0]),
            .i_b   (w_b_in[CHUNK-1:0]),
            .i_cin (w_c[k]),
            .o_sum (w_csum),
            .o_cout(w_cout),
            .o_cmsb(w_cmsb)
        );

        if (CHUNK == WIDTH) begin : g_single
            assign w_x_next = w_csum;
        end else begin : g_shift
            assign w_x_next = {w_csum, w_x[k][WIDTH-1:CHUNK]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_x <= '0;
                r_c <= 1'b0;
                r_v <= 1'b0;
            end else if (w_en) begin
                r_x <= w_x_next;
                r_c <= w_cout;
                r_v <= w_v[k];
            end
        end

        assign w_x[k+1] = r_x;
        assign w_c[k+1] = r_c;
        assign w_v[k+1] = r_v;

        if (k < STAGES - 1) begin : g_fwd
            localparam int NBO = b_off(k + 1, WIDTH, CHUNK);
            logic [REM-CHUNK-1:0] r_b;
            logic                 w_cmsb_unused;

            // Carry into the MSB only matters for the sign bit in the last slice.
            assign w_cmsb_unused = w_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_b <= '0;
                end else if (w_en) begin
                    r_b <= w_b_in[REM-1:CHUNK];
                end
            end

            assign w_b_flat[NBO+:REM-CHUNK] = r_b;
        end else begin : g_last
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cmsb <= 1'b0;
                end else if (w_en) begin
                    r_cmsb <= w_cmsb;
                end
            end
        end
    end

    assign out_valid = w_v[STAGES];
    assign sum       = w_x[STAGES];
    assign cout      = w_c[STAGES];
    assign ovf       = r_cmsb ^ w_c[STAGES];

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: 16/4 directed and backpressure cases plus
// an exhaustive 4/2 instance checked against a reference model.
module tb_add_pipe;

    localparam int W  = 16;
    localparam int S  = 4;
    localparam int W2 = 4;
    localparam int S2 = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, sum;
    logic          cin, op, cout, ovf;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [W2-1:0] a2, b2, sum2;
    logic          cin2, op2, cout2, ovf2;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    add_pipe #(.WIDTH(W2), .STAGES(S2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .cin(cin2), .op(op2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    typedef struct {
        logic [31:0] res;
        int          acc;
    } exp_t;

    exp_t        q[$];
    exp_t        q2[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    bit          chk_lat;
    bit          accepted;
    bit          drv_exp_en;
    logic [31:0] drv_exp;
    logic        p_ov, p_or;
    logic [31:0] p_out;

    // Directed arithmetic cases; expected is {ovf, cout, sum}.
    logic [15:0] dir_a   [7] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234, 16'h0000};
    logic [15:0] dir_b   [7] = '{16'h0001, 16'h0000, 16'h0001, 16'h0007, 16'h0001, 16'h1234, 16'h0000};
    logic        dir_cin [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        dir_op  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] dir_exp [7] = '{32'h0_0100, 32'h1_0000, 32'h2_8000, 32'h0_FFFE,
                                 32'h3_7FFF, 32'h1_0000, 32'h1_0000};

    function automatic logic [31:0] model(input int w, input logic [15:0] a_i,
                                          input logic [15:0] b_i, input logic cin_i,
                                          input logic op_i);
        int mask, bb, c0, full, s, co, sa, sb, ss, ov;
        mask = (1 << w) - 1;
        bb   = op_i ? (~int'(b_i)) & mask : int'(b_i) & mask;
        c0   = op_i ? 1 : int'(cin_i);
        full = (int'(a_i) & mask) + bb + c0;
        s    = full & mask;
        co   = (full >> w) & 1;
        sa   = (int'(a_i) >> (w - 1)) & 1;
        sb   = (bb >> (w - 1)) & 1;
        ss   = (s >> (w - 1)) & 1;
        ov   = (sa == sb && ss != sa) ? 1 : 0;
        return 32'((ov << (w + 1)) | (co << w) | s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at the falling edge, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (p_ov && !p_or) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", {13'd0, ovf, cout, sum}, p_out);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("result", {13'd0, ovf, cout, sum}, e.res);
                if (chk_lat) check("latency", 32'(cyc - e.acc), 32'(S));
            end
        end
        if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                check("unexpected_out2", 32'(out_valid2), 32'd0);
            end else begin
                e = q2.pop_front();
                check("result_w4", {26'd0, ovf2, cout2, sum2}, e.res);
                check("latency_w4", 32'(cyc - e.acc), 32'(S2));
            end
        end
        accepted = in_valid && in_ready;
        if (accepted)
            q.push_back('{res: (drv_exp_en ? drv_exp : model(W, a, b, cin, op)), acc: cyc});
        if (in_valid2 && in_ready2)
            q2.push_back('{res: model(W2, {12'd0, a2}, {12'd0, b2}, cin2, op2), acc: cyc});
        p_ov  = out_valid;
        p_or  = out_ready;
        p_out = {13'd0, ovf, cout, sum};
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i;
        bit  tog;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; op2 = 1'b0; out_ready2 = 1'b1;
        chk_lat = 1'b0; drv_exp_en = 1'b0; drv_exp = '0;
        p_ov = 1'b0; p_or = 1'b0; p_out = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Directed ADD/SUB, back-to-back, fixed latency
        chk_lat = 1'b1;
        drv_exp_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1; a = dir_a[k]; b = dir_b[k]; cin = dir_cin[k]; op = dir_op[k];
            drv_exp = dir_exp[k];
            tick();
        end
        in_valid = 1'b0;
        drv_exp_en = 1'b0;
        for (int g = 0; g < 20 && q.size() > 0; g++) tick();
        check("drain_directed", 32'(q.size()), 32'd0);

        // Backpressure: 8 ops while out_ready toggles
        chk_lat = 1'b0;
        i = 0;
        tog = 1'b1;
        for (int g = 0; g < 60 && i < 8; g++) begin
            in_valid = 1'b1; a = 16'(i); b = 16'(16'h1000 * i); cin = 1'b0; op = 1'b0;
            out_ready = tog;
            tog = !tog;
            tick();
            if (accepted) i++;
        end
        check("bp_all_accepted", 32'(i), 32'd8);
        in_valid = 1'b0;
        for (int g = 0; g < 40 && q.size() > 0; g++) begin
            out_ready = tog;
            tog = !tog;
            tick();
        end
        check("drain_backpressure", 32'(q.size()), 32'd0);

        // Reset mid-stream with results in flight and one stalled at the output
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; a = 16'(16'h0100 * (k + 1)); b = 16'h0011; cin = 1'b0; op = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_flags", {30'd0, cout, ovf}, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        q.delete();
        p_ov = 1'b0;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int g = 0; g < 10; g++) tick();
        check("no_stale", 32'(out_valid), 32'd0);

        // Exhaustive 4-bit / 2-stage configuration
        for (int o = 0; o < 2; o++)
            for (int c = 0; c < 2; c++)
                for (int x = 0; x < 16; x++)
                    for (int y = 0; y < 16; y++) begin
                        in_valid2 = 1'b1; a2 = 4'(x); b2 = 4'(y); cin2 = c[0]; op2 = o[0];
                        tick();
                    end
        in_valid2 = 1'b0;
        for (int g = 0; g < 10 && q2.size() > 0; g++) tick();
        check("drain_exhaustive", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
